// File: rtl/regwrite_pkg.sv
// Shared defaults and types for the register-file write-port arbiter.
package regwrite_pkg;
  localparam int DATA_W_DEF    = 16;
  localparam int ADDR_W_DEF    = 4;
  localparam int NREGS_DEF     = 16;
  localparam int MAX_LOADS_DEF = 2;

  // Source selected for the write-port this cycle
  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_EX   = 2'd1,
    WB_LD   = 2'd2
  } wb_src_t;

  // Pointer width for a queue of the given depth (a depth of 1 still needs one bit)
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/load_tag_fifo.sv
// In-order queue of destination registers for outstanding loads.
// Exposes every slot plus a per-slot valid vector so the top can build a busy mask.
module load_tag_fifo
  import regwrite_pkg::*;
#(
  parameter int DEPTH = MAX_LOADS_DEF,
  parameter int W     = ADDR_W_DEF,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [W-1:0]              push_data,
  input  logic                      pop,
  output logic [CW-1:0]             count,
  output logic [W-1:0]              head,
  output logic [DEPTH-1:0][W-1:0]   entries,
  output logic [DEPTH-1:0]          vld
);
  localparam int PW = ptr_w(DEPTH);

  logic [DEPTH-1:0][W-1:0] r_mem;
  logic [DEPTH-1:0]        r_vld;
  logic [PW-1:0]           r_wr;
  logic [PW-1:0]           r_rd;
  logic [CW-1:0]           r_cnt;

  // Wrap a pointer modulo DEPTH (DEPTH need not be a power of two)
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Queue state: push at tail, pop at head; the caller never pops when empty
  // or pushes when full, so push and pop never hit the same live slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem <= '0;
      r_vld <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (pop) begin
        r_vld[r_rd] <= 1'b0;
        r_rd        <= nxt(r_rd);
      end
      if (push) begin
        r_mem[r_wr] <= push_data;
        r_vld[r_wr] <= 1'b1;
        r_wr        <= nxt(r_wr);
      end
      case ({push, pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign count   = r_cnt;
  assign head    = r_mem[r_rd];
  assign entries = r_mem;
  assign vld     = r_vld;
endmodule

// File: rtl/regwrite_arbiter.sv
// Single register-file write port shared by execute write-back and load returns.
// Load responses cannot be stalled, so they always win; execute writes also stall
// while their destination still has a load outstanding (keeps WAW order).
module regwrite_arbiter
  import regwrite_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int NREGS     = NREGS_DEF,
  parameter int MAX_LOADS = MAX_LOADS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              ld_issue,
  input  logic [ADDR_W-1:0] ld_issue_addr,
  output logic              ld_issue_ready,
  input  logic              ld_resp_valid,
  input  logic [DATA_W-1:0] ld_resp_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [NREGS-1:0]  busy_mask,
  output logic              err_spurious
);
  localparam int CW = $clog2(MAX_LOADS + 1);

  logic [CW-1:0]                     w_cnt;
  logic [ADDR_W-1:0]                 w_head;
  logic [MAX_LOADS-1:0][ADDR_W-1:0]  w_entries;
  logic [MAX_LOADS-1:0]              w_vld;
  logic                              w_ld_win;
  logic                              w_spur;
  logic                              w_push;
  logic                              w_ex_acc;
  wb_src_t                           w_src;

  logic              r_rf_we;
  logic [ADDR_W-1:0] r_rf_waddr;
  logic [DATA_W-1:0] r_rf_wdata;
  logic              r_err;

  load_tag_fifo #(
    .DEPTH (MAX_LOADS),
    .W     (ADDR_W),
    .CW    (CW)
  ) u_tags (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (ld_issue_addr),
    .pop       (w_ld_win),
    .count     (w_cnt),
    .head      (w_head),
    .entries   (w_entries),
    .vld       (w_vld)
  );

  // A response only counts as a load write when there is a tag to retire
  assign w_ld_win       = ld_resp_valid && (w_cnt != '0);
  assign w_spur         = ld_resp_valid && (w_cnt == '0);
  // Room is judged on the registered count; a same-cycle pop does not help
  assign ld_issue_ready = (w_cnt < CW'(MAX_LOADS));
  assign w_push         = ld_issue && ld_issue_ready;
  assign ex_ready       = !w_ld_win && !busy_mask[ex_addr];
  assign w_ex_acc       = ex_valid && ex_ready;

  // Busy mask: OR of one-hot decodes of every live tag (duplicates allowed)
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < MAX_LOADS; i++) begin
      if (w_vld[i]) busy_mask[w_entries[i]] = 1'b1;
    end
  end

  // Pick the write-port source: load return first, then execute
  always_comb begin
    w_src = WB_NONE;
    if (w_ld_win)      w_src = WB_LD;
    else if (w_ex_acc) w_src = WB_EX;
  end

  // Registered write port; address/data hold when nothing is written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else begin
      case (w_src)
        WB_LD: begin
          r_rf_we    <= 1'b1;
          r_rf_waddr <= w_head;
          r_rf_wdata <= ld_resp_data;
        end
        WB_EX: begin
          r_rf_we    <= 1'b1;
          r_rf_waddr <= ex_addr;
          r_rf_wdata <= ex_data;
        end
        default: r_rf_we <= 1'b0;
      endcase
    end
  end

  // Sticky flag for a load response with no outstanding load
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_err <= 1'b0;
    else if (w_spur) r_err <= 1'b1;
  end

  assign rf_we        = r_rf_we;
  assign rf_waddr     = r_rf_waddr;
  assign rf_wdata     = r_rf_wdata;
  assign err_spurious = r_err;
endmodule
